// File: rtl/cnn_layer_sched.sv
// Layer scheduler: queues host descriptors and sequences them through the CNN accelerator.
// Optional watchdog on RUN/POOL enabled by defining CNN_SCHED_TIMEOUT_EN.
module cnn_layer_sched #(
   parameter int DEPTH   = 4,
   parameter int OPW     = 14,
   parameter int CLR_CYC = 2,
   parameter int TMO_W   = 16
) (
   input  logic           clk,
   input  logic           nrst,
   input  logic [OPW-1:0] desc_i,
   input  logic           desc_vld_i,
   output logic           desc_rdy_o,
   input  logic           go_i,
   input  logic           abort_i,
   input  logic           conv_finish_i,
   input  logic           pool_finish_i,
   output logic [OPW-1:0] op_code_o,
   output logic           acc_nrst_o,
   output logic           busy_o,
   output logic           done_o,
   output logic           err_o,
   output logic [7:0]     layer_cnt_o
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int CCW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

   localparam logic [2:0] MODE_CONV = 3'b001;
   localparam logic [2:0] MODE_POOL = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_RUN,
      S_POOL,
      S_NEXT,
      S_ERR
   } state_t;

   state_t         state, nxt;
   logic [OPW-1:0] mem [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic [2:0]     mode;
   logic [CCW-1:0] clr_cnt;
   logic           empty, full, push, pop, flush, done_nxt, go_acc, tmo, legal;

   assign empty = (cnt == '0);
   assign full  = (cnt == CW'(DEPTH));
   assign push  = desc_vld_i && !full;
   assign legal = (mode == MODE_CONV) || (mode == MODE_POOL);

`ifdef CNN_SCHED_TIMEOUT_EN
   logic [TMO_W-1:0] wdog;
   logic [TMO_W-1:0] wdog_inc;

   assign wdog_inc = wdog + TMO_W'(1);
   assign tmo      = &wdog_inc;

   always_ff @(posedge clk) begin
      if (!nrst)
         wdog <= '0;
      else if (pop)
         wdog <= '0;
      else if (state == S_RUN || state == S_POOL)
         wdog <= wdog_inc;
   end
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      nxt      = state;
      done_nxt = 1'b0;
      flush    = 1'b0;
      go_acc   = 1'b0;
      case (state)
         S_IDLE: begin
            if (go_i && !empty) begin
               nxt    = S_CLR;
               go_acc = 1'b1;
            end
         end
         S_CLR: begin
            // finish levels are deliberately not looked at here: they may be stale
            if (clr_cnt == CCW'(CLR_CYC - 1))
               nxt = legal ? S_RUN : S_ERR;
         end
         S_RUN: begin
            if (conv_finish_i)
               nxt = (mode == MODE_POOL) ? S_POOL : S_NEXT;
            else if (tmo)
               nxt = S_ERR;
         end
         S_POOL: begin
            if (pool_finish_i)
               nxt = S_NEXT;
            else if (tmo)
               nxt = S_ERR;
         end
         S_NEXT: begin
            if (!empty) begin
               nxt = S_CLR;
            end else begin
               nxt      = S_IDLE;
               done_nxt = 1'b1;
            end
         end
         S_ERR: begin
            nxt      = S_IDLE;
            flush    = 1'b1;
            done_nxt = 1'b1;
         end
         default: nxt = S_IDLE;
      endcase
      if (abort_i) begin
         nxt      = S_IDLE;
         flush    = 1'b1;
         done_nxt = 1'b0;
         go_acc   = 1'b0;
      end
   end

   assign pop = (nxt == S_CLR) && (state != S_CLR);

   always_comb begin
      if (flush)
         cnt_nxt = '0;
      else
         cnt_nxt = cnt + CW'(push) - CW'(pop);
   end

   // storage needs no reset: occupancy and pointers decide what is valid
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= desc_i;
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state       <= S_IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         cnt         <= '0;
         mode        <= '0;
         clr_cnt     <= '0;
         desc_rdy_o  <= 1'b1;
         op_code_o   <= '0;
         acc_nrst_o  <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         layer_cnt_o <= '0;
      end else begin
         state      <= nxt;
         cnt        <= cnt_nxt;
         desc_rdy_o <= (cnt_nxt != CW'(DEPTH));
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
         end

         if (pop)
            clr_cnt <= '0;
         else if (state == S_CLR)
            clr_cnt <= clr_cnt + CCW'(1);

         if (pop) begin
            op_code_o <= mem[rd_ptr];
            mode      <= mem[rd_ptr][2:0];
         end else if (nxt == S_IDLE) begin
            op_code_o <= '0;
         end

         // abort forces one low cycle on the accelerator reset even though we land in IDLE
         acc_nrst_o <= !((nxt == S_CLR) || (abort_i && state != S_IDLE));
         // busy stays up through the done pulse so the host sees done before busy drops
         busy_o     <= (nxt != S_IDLE) || done_nxt;
         done_o     <= done_nxt;

         if (go_acc)
            err_o <= 1'b0;
         else if (nxt == S_ERR)
            err_o <= 1'b1;

         if (go_acc)
            layer_cnt_o <= '0;
         else if (state == S_NEXT && !abort_i && layer_cnt_o != 8'hFF)
            layer_cnt_o <= layer_cnt_o + 8'd1;
      end
   end

endmodule

// File: tb/tb_cnn_layer_sched.sv
// Self-checking bench for cnn_layer_sched: vector table, scoreboard of issued op_codes, corner sequences.
module tb_cnn_layer_sched;

   localparam int DEPTH   = 4;
   localparam int OPW     = 14;
   localparam int CLR_CYC = 2;
   localparam int TMO_W   = 4;

   logic           clk = 1'b0;
   logic           nrst;
   logic [OPW-1:0] desc_i;
   logic           desc_vld_i, desc_rdy_o, go_i, abort_i, conv_finish_i, pool_finish_i;
   logic [OPW-1:0] op_code_o;
   logic           acc_nrst_o, busy_o, done_o, err_o;
   logic [7:0]     layer_cnt_o;

   int n_chk  = 0;
   int n_fail = 0;
   logic [OPW-1:0] sb[$];
   logic           prev_acc = 1'b0;

   typedef struct {
      logic [OPW-1:0] desc;
      logic           exp_rdy;
   } vec_t;

   cnn_layer_sched #(.DEPTH(DEPTH), .OPW(OPW), .CLR_CYC(CLR_CYC), .TMO_W(TMO_W)) dut (
      .clk(clk), .nrst(nrst), .desc_i(desc_i), .desc_vld_i(desc_vld_i), .desc_rdy_o(desc_rdy_o),
      .go_i(go_i), .abort_i(abort_i), .conv_finish_i(conv_finish_i), .pool_finish_i(pool_finish_i),
      .op_code_o(op_code_o), .acc_nrst_o(acc_nrst_o), .busy_o(busy_o), .done_o(done_o),
      .err_o(err_o), .layer_cnt_o(layer_cnt_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got stuck want finished");
      $fatal(1, "timeout");
   end

   // scoreboard: each new CLR phase must present the next accepted descriptor
   always @(negedge clk) begin
      if (busy_o && !acc_nrst_o && prev_acc) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got op_code %0h want no layer", op_code_o);
         end else begin
            logic [OPW-1:0] e;
            e = sb.pop_front();
            if (op_code_o !== e) begin
               n_fail++;
               $display("FAIL sb_op_code: got %0h want %0h", op_code_o, e);
            end
         end
      end
      prev_acc = acc_nrst_o;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [OPW-1:0] d, input logic accept);
      desc_i     = d;
      desc_vld_i = 1'b1;
      step();
      desc_vld_i = 1'b0;
      if (accept) sb.push_back(d);
   endtask

   task automatic go();
      go_i = 1'b1;
      step();
      go_i = 1'b0;
   endtask

   // wait for the CLR phase to start and end: returns just after RUN is entered
   task automatic wait_run();
      int n;
      n = 0;
      while (acc_nrst_o !== 1'b0 && n < 50) begin step(); n++; end
      if (n >= 50) chk("wait_clr_timeout", 32'd0, 32'd1);
      n = 0;
      while (acc_nrst_o !== 1'b1 && n < 50) begin step(); n++; end
      if (n >= 50) chk("wait_run_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_layer(input logic [2:0] m);
      wait_run();
      conv_finish_i = 1'b1;
      step();
      conv_finish_i = 1'b0;
      if (m == 3'b010) begin
         pool_finish_i = 1'b1;
         step();
         pool_finish_i = 1'b0;
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done_o !== 1'b1 && n < 50) begin step(); n++; end
      chk("wait_done", {31'd0, done_o}, 32'd1);
   endtask

   initial begin
      vec_t vecs[5];
      vecs[0] = '{14'h0001, 1'b1};
      vecs[1] = '{14'h0011, 1'b1};
      vecs[2] = '{14'h0002, 1'b1};
      vecs[3] = '{14'h0009, 1'b1};
      vecs[4] = '{14'h00A1, 1'b0};

      nrst = 1'b0; desc_i = '0; desc_vld_i = 0; go_i = 0; abort_i = 0;
      conv_finish_i = 0; pool_finish_i = 0;

      // reset values
      step(); step();
      chk("rst_acc_nrst", {31'd0, acc_nrst_o}, 32'd0);
      chk("rst_rdy", {31'd0, desc_rdy_o}, 32'd1);
      chk("rst_op", {18'd0, op_code_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      chk("rst_cnt", {24'd0, layer_cnt_o}, 32'd0);
      nrst = 1'b1;
      step();
      chk("rel_acc_nrst", {31'd0, acc_nrst_o}, 32'd1);

      // two-layer batch: conv-only then conv+pool
      push(14'h0001, 1'b1);
      push(14'h0002, 1'b1);
      go();
      chk("go_busy", {31'd0, busy_o}, 32'd1);
      chk("go_acc_low", {31'd0, acc_nrst_o}, 32'd0);
      chk("go_op", {18'd0, op_code_o}, 32'h1);
      step();
      chk("clr2_acc_low", {31'd0, acc_nrst_o}, 32'd0);
      step();
      chk("run_acc_high", {31'd0, acc_nrst_o}, 32'd1);
      conv_finish_i = 1'b1;
      step();
      conv_finish_i = 1'b0;
      chk("next_cnt0", {24'd0, layer_cnt_o}, 32'd0);
      step();
      chk("l2_cnt1", {24'd0, layer_cnt_o}, 32'd1);
      chk("l2_op", {18'd0, op_code_o}, 32'h2);
      chk("l2_acc_low", {31'd0, acc_nrst_o}, 32'd0);
      step(); step();
      chk("l2_run", {31'd0, acc_nrst_o}, 32'd1);
      conv_finish_i = 1'b1;
      step();
      conv_finish_i = 1'b0;
      pool_finish_i = 1'b1;
      step();
      pool_finish_i = 1'b0;
      chk("l2_no_early_done", {31'd0, done_o}, 32'd0);
      step();
      chk("b1_done", {31'd0, done_o}, 32'd1);
      chk("b1_cnt2", {24'd0, layer_cnt_o}, 32'd2);
      step();
      chk("b1_done_pulse", {31'd0, done_o}, 32'd0);
      chk("b1_idle", {31'd0, busy_o}, 32'd0);

      // fill the FIFO from the table; 5th push refused
      foreach (vecs[i]) begin
         chk("fill_rdy", {31'd0, desc_rdy_o}, {31'd0, vecs[i].exp_rdy});
         push(vecs[i].desc, vecs[i].exp_rdy);
      end
      chk("full_rdy", {31'd0, desc_rdy_o}, 32'd0);
      // push while full refused even though go pops this cycle
      desc_i = 14'h00FF; desc_vld_i = 1'b1;
      go();
      desc_vld_i = 1'b0;
      chk("pop_rdy", {31'd0, desc_rdy_o}, 32'd1);
      run_layer(3'b001);
      run_layer(3'b001);
      run_layer(3'b010);
      run_layer(3'b001);
      wait_done();
      chk("fill_cnt4", {24'd0, layer_cnt_o}, 32'd4);
      chk("fill_no_err", {31'd0, err_o}, 32'd0);
      step();

      // illegal mode after a good layer
      push(14'h0001, 1'b1);
      push(14'h0007, 1'b1);
      go();
      run_layer(3'b001);
      wait_done();
      chk("ill_err", {31'd0, err_o}, 32'd1);
      chk("ill_cnt1", {24'd0, layer_cnt_o}, 32'd1);
      chk("ill_rdy", {31'd0, desc_rdy_o}, 32'd1);
      step();
      chk("ill_done_pulse", {31'd0, done_o}, 32'd0);
      chk("ill_idle", {31'd0, busy_o}, 32'd0);
      // go with an empty FIFO does nothing (and keeps err)
      go();
      chk("empty_go_busy", {31'd0, busy_o}, 32'd0);
      step();
      chk("empty_go_done", {31'd0, done_o}, 32'd0);
      chk("empty_go_err", {31'd0, err_o}, 32'd1);

      // mode 010: pool alone ignored in RUN, both together -> POOL then NEXT
      push(14'h0002, 1'b1);
      go();
      wait_run();
      pool_finish_i = 1'b1;
      step(); step(); step();
      chk("pool_only_busy", {31'd0, busy_o}, 32'd1);
      chk("pool_only_cnt", {24'd0, layer_cnt_o}, 32'd0);
      conv_finish_i = 1'b1;
      step(); step();
      chk("both_no_done", {31'd0, done_o}, 32'd0);
      chk("both_cnt0", {24'd0, layer_cnt_o}, 32'd0);
      step();
      chk("both_done", {31'd0, done_o}, 32'd1);
      chk("both_cnt1", {24'd0, layer_cnt_o}, 32'd1);
      conv_finish_i = 1'b0; pool_finish_i = 1'b0;
      step();
      chk("both_idle", {31'd0, busy_o}, 32'd0);

      // abort mid-RUN with two queued
      push(14'h0001, 1'b1); push(14'h0001, 1'b1); push(14'h0001, 1'b1);
      go();
      wait_run();
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      sb.delete();
      chk("abort_busy", {31'd0, busy_o}, 32'd0);
      chk("abort_acc_low", {31'd0, acc_nrst_o}, 32'd0);
      chk("abort_op", {18'd0, op_code_o}, 32'd0);
      chk("abort_no_done", {31'd0, done_o}, 32'd0);
      chk("abort_err", {31'd0, err_o}, 32'd0);
      step();
      chk("abort_acc_rel", {31'd0, acc_nrst_o}, 32'd1);
      chk("abort_no_done2", {31'd0, done_o}, 32'd0);
      go();
      chk("abort_flushed", {31'd0, busy_o}, 32'd0);

      // nrst mid-batch
      push(14'h0001, 1'b1); push(14'h0001, 1'b1); push(14'h0001, 1'b1);
      go();
      wait_run();
      nrst = 1'b0;
      step();
      sb.delete();
      chk("mrst_acc", {31'd0, acc_nrst_o}, 32'd0);
      chk("mrst_busy", {31'd0, busy_o}, 32'd0);
      chk("mrst_op", {18'd0, op_code_o}, 32'd0);
      chk("mrst_rdy", {31'd0, desc_rdy_o}, 32'd1);
      chk("mrst_cnt", {24'd0, layer_cnt_o}, 32'd0);
      nrst = 1'b1;
      step();
      chk("mrst_rel_acc", {31'd0, acc_nrst_o}, 32'd1);
      go();
      chk("mrst_flushed", {31'd0, busy_o}, 32'd0);

      // no finish: watchdog or indefinite wait
      push(14'h0001, 1'b1);
      go();
      wait_run();
`ifdef CNN_SCHED_TIMEOUT_EN
      repeat (14) step();
      chk("tmo_not_yet", {31'd0, err_o}, 32'd0);
      step();
      chk("tmo_err", {31'd0, err_o}, 32'd1);
      step();
      chk("tmo_done", {31'd0, done_o}, 32'd1);
      step();
`else
      repeat (1000) step();
      chk("hang_busy", {31'd0, busy_o}, 32'd1);
      chk("hang_no_done", {31'd0, done_o}, 32'd0);
      chk("hang_no_err", {31'd0, err_o}, 32'd0);
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      step();
`endif
      chk("sb_drained", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
